// File: rtl/gmii_rx_framer_if.sv
// Output beat bus of the GMII/MII receive framer: one strobe per packed word,
// with byte enables, last marker, frame error and frame length.
interface gmii_rx_framer_if #(
  parameter int OUT_BYTES = 4,
  parameter int CNT_W     = 16
);
  logic                   o_valid;
  logic [8*OUT_BYTES-1:0] o_data;
  logic [OUT_BYTES-1:0]   o_keep;
  logic                   o_last;
  logic                   o_err;
  logic [CNT_W-1:0]       o_byte_cnt;

  // Framer side drives the beats.
  modport master (
    output o_valid, o_data, o_keep, o_last, o_err, o_byte_cnt
  );

  // FIFO side consumes the beats; there is no backpressure.
  modport slave (
    input o_valid, o_data, o_keep, o_last, o_err, o_byte_cnt
  );
endinterface

// File: rtl/gmii_rx_framer.sv
// Receive framer: strips preamble/SFD from a GMII byte or MII nibble stream and
// packs frame bytes little-endian into OUT_BYTES-wide beats. A filled word is
// held back until the next byte or the end of frame, so the final beat always
// carries real data (or is the single empty beat of a zero-length frame).
module gmii_rx_framer #(
  parameter int OUT_BYTES = 4,
  parameter int MAX_FRAME = 1522,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MII_SEL,
  input  logic [7:0]       RX_D,
  input  logic             RX_EN,
  input  logic             RX_ERR,
  gmii_rx_framer_if.master beat
);

  localparam int W      = 8 * OUT_BYTES;
  localparam int FILL_W = $clog2(OUT_BYTES + 1);
  localparam logic [FILL_W-1:0] FULL    = FILL_W'(OUT_BYTES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_FRAME);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t             state_reg, state_next;
  logic               mii_reg, mii_next;
  logic               phase_reg, phase_next;
  logic [3:0]         nib_reg, nib_next;
  logic [W-1:0]       stage_reg, stage_next;
  logic [FILL_W-1:0]  fill_reg, fill_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               err_reg, err_next;

  logic               valid_reg, valid_next;
  logic [W-1:0]       data_reg, data_next;
  logic [OUT_BYTES-1:0] keep_reg, keep_next;
  logic               last_reg, last_next;
  logic               oerr_reg, oerr_next;
  logic [CNT_W-1:0]   bcnt_reg, bcnt_next;

  logic               mii_eff;
  logic               byte_ok;
  logic [7:0]         byte_val;
  logic               stage_full;
  logic [FILL_W-1:0]  ins_lane;
  logic [OUT_BYTES-1:0] keep_mask;
  logic [W-1:0]       packed_word;

  // The mode is live from MII_SEL only on the first cycle of a frame; after the
  // first nibble (or outside IDLE) the latched copy is used.
  assign mii_eff    = (state_reg == IDLE && !phase_reg) ? MII_SEL : mii_reg;
  assign byte_ok    = RX_EN && (!mii_eff || phase_reg);
  assign byte_val   = mii_eff ? {RX_D[3:0], nib_reg} : RX_D;
  assign stage_full = (fill_reg == FULL);
  // A full staging word is flushed out, so the new byte restarts at lane 0.
  assign ins_lane   = stage_full ? '0 : fill_reg;

  genvar gi;
  generate
    for (gi = 0; gi < OUT_BYTES; gi++) begin : g_lane
      assign keep_mask[gi] = (FILL_W'(gi) < fill_reg);
      assign packed_word[8*gi +: 8] = (FILL_W'(gi) == ins_lane) ? byte_val :
                                      (stage_full ? 8'h00 : stage_reg[8*gi +: 8]);
    end
  endgenerate

  // Next-state, packing and beat generation.
  always_comb begin
    state_next = state_reg;
    mii_next   = mii_reg;
    phase_next = phase_reg;
    nib_next   = nib_reg;
    stage_next = stage_reg;
    fill_next  = fill_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    valid_next = 1'b0;
    data_next  = '0;
    keep_next  = '0;
    last_next  = 1'b0;
    oerr_next  = 1'b0;
    bcnt_next  = '0;

    // Nibble phase runs in every state and collapses whenever RX_EN drops.
    if (RX_EN && mii_eff) begin
      phase_next = ~phase_reg;
      if (!phase_reg) begin
        nib_next = RX_D[3:0];
      end
    end else begin
      phase_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (!phase_reg) begin
          mii_next = MII_SEL;
        end
        if (byte_ok) begin
          state_next = (byte_val == 8'h55) ? PREAMBLE : DROP;
        end
      end
      PREAMBLE: begin
        if (!RX_EN) begin
          state_next = IDLE;
        end else if (byte_ok) begin
          if (byte_val == 8'hD5) begin
            state_next = DATA;
            cnt_next   = '0;
            fill_next  = '0;
            stage_next = '0;
            err_next   = 1'b0;
          end else if (byte_val != 8'h55) begin
            state_next = DROP;
          end
        end
      end
      DATA: begin
        if (!RX_EN) begin
          // End of frame: flush whatever is staged as the last beat. A pending
          // low nibble or an empty frame both mark the frame bad.
          valid_next = 1'b1;
          last_next  = 1'b1;
          data_next  = stage_reg;
          keep_next  = keep_mask;
          bcnt_next  = cnt_reg;
          oerr_next  = err_reg | (mii_reg & phase_reg) | (cnt_reg == '0);
          state_next = IDLE;
        end else begin
          if (RX_ERR) begin
            err_next = 1'b1;
          end
          if (byte_ok) begin
            if (cnt_reg == CNT_MAX) begin
              // Oversize: the extra byte is dropped and the frame is closed now.
              valid_next = 1'b1;
              last_next  = 1'b1;
              data_next  = stage_reg;
              keep_next  = keep_mask;
              bcnt_next  = cnt_reg;
              oerr_next  = 1'b1;
              err_next   = 1'b1;
              state_next = DROP;
            end else begin
              if (stage_full) begin
                valid_next = 1'b1;
                data_next  = stage_reg;
                keep_next  = '1;
              end
              stage_next = packed_word;
              fill_next  = stage_full ? FILL_W'(1) : fill_reg + FILL_W'(1);
              cnt_next   = cnt_reg + CNT_W'(1);
            end
          end
        end
      end
      DROP: begin
        if (!RX_EN) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      mii_reg   <= 1'b0;
      phase_reg <= 1'b0;
      nib_reg   <= '0;
      stage_reg <= '0;
      fill_reg  <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
      keep_reg  <= '0;
      last_reg  <= 1'b0;
      oerr_reg  <= 1'b0;
      bcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      mii_reg   <= mii_next;
      phase_reg <= phase_next;
      nib_reg   <= nib_next;
      stage_reg <= stage_next;
      fill_reg  <= fill_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      valid_reg <= valid_next;
      data_reg  <= data_next;
      keep_reg  <= keep_next;
      last_reg  <= last_next;
      oerr_reg  <= oerr_next;
      bcnt_reg  <= bcnt_next;
    end
  end

  assign beat.o_valid    = valid_reg;
  assign beat.o_data     = data_reg;
  assign beat.o_keep     = keep_reg;
  assign beat.o_last     = last_reg;
  assign beat.o_err      = oerr_reg;
  assign beat.o_byte_cnt = bcnt_reg;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Bench for gmii_rx_framer: directed frames from the test plan followed by
// random GMII/MII frames, compared beat by beat (content and arrival cycle)
// against a frame-level reference model.
`timescale 1ns/1ps
module tb_gmii_rx_framer;
  localparam int OB   = 4;
  localparam int MAXF = 16;
  localparam int CW   = 16;

  typedef struct {
    logic [8*OB-1:0] data;
    logic [OB-1:0]   keep;
    logic            last;
    logic            err;
    logic [CW-1:0]   cnt;
    int              stamp;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mii_sel = 1'b0;
  logic [7:0] rx_d = 8'h00;
  logic       rx_en = 1'b0;
  logic       rx_err = 1'b0;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    n_obs = 0;
  int    n_exp = 0;
  bit    scramble = 1'b0;
  beat_t obs_q[$];
  beat_t exp_q[$];
  logic [7:0] frame_data[$];

  gmii_rx_framer_if #(.OUT_BYTES(OB), .CNT_W(CW)) beat_bus ();

  gmii_rx_framer #(.OUT_BYTES(OB), .MAX_FRAME(MAXF), .CNT_W(CW)) dut (
    .CLK     (clk),
    .RST     (rst),
    .MII_SEL (mii_sel),
    .RX_D    (rx_d),
    .RX_EN   (rx_en),
    .RX_ERR  (rx_err),
    .beat    (beat_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [8*OB-1:0] keep_to_mask(input logic [OB-1:0] k);
    logic [8*OB-1:0] m;
    m = '0;
    for (int i = 0; i < OB; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Capture beats on the falling edge and pair them with expected beats in order.
  always @(negedge clk) begin
    beat_t o, x;
    if (beat_bus.o_valid) begin
      o.data  = beat_bus.o_data;
      o.keep  = beat_bus.o_keep;
      o.last  = beat_bus.o_last;
      o.err   = beat_bus.o_err;
      o.cnt   = beat_bus.o_byte_cnt;
      o.stamp = cyc;
      obs_q.push_back(o);
      n_obs++;
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      $display("beat t=%0d data=%h keep=%b last=%b err=%b cnt=%0d", o.stamp, o.data, o.keep, o.last, o.err, o.cnt);
      check_eq("beat_keep", 64'(o.keep), 64'(x.keep));
      check_eq("beat_data", 64'(o.data & keep_to_mask(x.keep)), 64'(x.data));
      check_eq("beat_last", 64'(o.last), 64'(x.last));
      if (x.last) begin
        check_eq("beat_err", 64'(o.err), 64'(x.err));
        check_eq("beat_cnt", 64'(o.cnt), 64'(x.cnt));
      end
      check_eq("beat_cycle", 64'(o.stamp), 64'(x.stamp));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of PHY inputs; returns the index of the edge that samples them.
  task automatic drive_cycle(input logic en, input logic [7:0] d, input logic er, output int edge_idx);
    rx_en  = en;
    rx_d   = d;
    rx_err = er;
    if (scramble) mii_sel = 1'($urandom_range(0, 1));
    edge_idx = cyc + 1;
    tick();
  endtask

  // One byte: a single GMII cycle, or low then high nibble with junk upper bits.
  task automatic drive_byte(input bit mii, input logic [7:0] b, input logic er, output int edge_idx);
    logic [3:0] junk;
    if (!mii) begin
      drive_cycle(1'b1, b, er, edge_idx);
    end else begin
      junk = 4'($urandom);
      drive_cycle(1'b1, {junk, b[3:0]}, er, edge_idx);
      junk = 4'($urandom);
      drive_cycle(1'b1, {junk, b[7:4]}, er, edge_idx);
    end
  endtask

  // Send preamble, SFD and frame_data, then predict the beats of this frame.
  task automatic drive_frame(input bit mii, input int pre_len, input int bad_at,
                             input int err_at, input bit dribble, input int gap);
    int    be[$];
    int    e, end_e, n, m, nb;
    beat_t x;
    n = frame_data.size();
    mii_sel = mii;
    for (int i = 0; i < pre_len; i++) begin
      drive_byte(mii, (i == bad_at) ? 8'h57 : 8'h55, 1'b0, e);
      scramble = 1'b1;
    end
    drive_byte(mii, 8'hD5, 1'b0, e);
    for (int i = 0; i < n; i++) begin
      drive_byte(mii, frame_data[i], (i == err_at), e);
      be.push_back(e);
    end
    if (mii && dribble) drive_cycle(1'b1, 8'($urandom), 1'b0, e);
    drive_cycle(1'b0, 8'($urandom), 1'b0, end_e);
    scramble = 1'b0;
    $display("frame mii=%0d pre=%0d bad=%0d len=%0d err_at=%0d dribble=%0d", mii, pre_len, bad_at, n, err_at, dribble);
    if (bad_at < 0) begin
      m  = (n > MAXF) ? MAXF : n;
      nb = (m == 0) ? 1 : (m + OB - 1) / OB;
      for (int j = 0; j < nb; j++) begin
        x.data = '0;
        x.keep = '0;
        for (int k = 0; k < OB; k++) begin
          if (j * OB + k < m) begin
            x.data[8*k +: 8] = frame_data[j * OB + k];
            x.keep[k] = 1'b1;
          end
        end
        x.last = (j == nb - 1);
        x.err  = x.last && ((n > MAXF) || (n == 0) || (mii && dribble) || (err_at >= 0 && err_at < n));
        x.cnt  = x.last ? CW'(m) : '0;
        if (!x.last) x.stamp = be[(j + 1) * OB];
        else if (n > MAXF) x.stamp = be[MAXF];
        else x.stamp = end_e;
        exp_q.push_back(x);
        n_exp++;
      end
    end
    for (int i = 0; i < gap; i++) drive_cycle(1'b0, 8'($urandom), 1'b0, e);
  endtask

  task automatic fill_random(input int n);
    frame_data.delete();
    for (int i = 0; i < n; i++) frame_data.push_back(8'($urandom));
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_valid"}, 64'(beat_bus.o_valid), 64'd0);
    check_eq({tag, "_data"},  64'(beat_bus.o_data), 64'd0);
    check_eq({tag, "_keep"},  64'(beat_bus.o_keep), 64'd0);
    check_eq({tag, "_last"},  64'(beat_bus.o_last), 64'd0);
    check_eq({tag, "_err"},   64'(beat_bus.o_err), 64'd0);
    check_eq({tag, "_cnt"},   64'(beat_bus.o_byte_cnt), 64'd0);
  endtask

  initial begin
    int    n, pre, bad, erra, gap, e;
    bit    mii, drib;
    beat_t x;

    rst = 1'b1;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) tick();

    // Basic GMII frame 0x01..0x0A.
    frame_data.delete();
    for (int i = 1; i <= 10; i++) frame_data.push_back(8'(i));
    drive_frame(1'b0, 7, -1, -1, 1'b0, 2);
    // Exact multiple of the word width.
    fill_random(8);
    drive_frame(1'b0, 7, -1, -1, 1'b0, 2);
    // MII with dribble nibble.
    fill_random(5);
    drive_frame(1'b1, 7, -1, -1, 1'b1, 2);
    // RX_ERR on byte 3 of 6.
    fill_random(6);
    drive_frame(1'b0, 7, -1, 2, 1'b0, 2);
    // Bad preamble byte.
    fill_random(6);
    drive_frame(1'b0, 7, 3, -1, 1'b0, 2);
    // Exactly MAX_FRAME, then one over.
    fill_random(16);
    drive_frame(1'b0, 7, -1, -1, 1'b0, 1);
    fill_random(17);
    drive_frame(1'b0, 7, -1, -1, 1'b0, 1);
    // Oversize followed back-to-back by a normal frame.
    fill_random(20);
    drive_frame(1'b0, 7, -1, -1, 1'b0, 0);
    fill_random(7);
    drive_frame(1'b0, 7, -1, -1, 1'b0, 2);
    // Runt frames in both modes.
    fill_random(0);
    drive_frame(1'b0, 7, -1, -1, 1'b0, 0);
    fill_random(0);
    drive_frame(1'b1, 3, -1, -1, 1'b0, 2);

    // Reset in the middle of DATA, one cycle after a beat is emitted.
    fill_random(5);
    mii_sel = 1'b0;
    for (int i = 0; i < 7; i++) drive_byte(1'b0, 8'h55, 1'b0, e);
    drive_byte(1'b0, 8'hD5, 1'b0, e);
    for (int i = 0; i < 5; i++) drive_byte(1'b0, frame_data[i], 1'b0, e);
    x.data  = {frame_data[3], frame_data[2], frame_data[1], frame_data[0]};
    x.keep  = 4'hF;
    x.last  = 1'b0;
    x.err   = 1'b0;
    x.cnt   = '0;
    x.stamp = e;
    exp_q.push_back(x);
    n_exp++;
    rst = 1'b1;
    drive_cycle(1'b1, 8'h55, 1'b0, e);
    check_outputs_zero("rst_mid");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 8'h00, 1'b0, e);

    // Random frames.
    for (int f = 0; f < 80; f++) begin
      n    = int'($urandom_range(0, 22));
      mii  = 1'($urandom_range(0, 1));
      pre  = int'($urandom_range(1, 7));
      bad  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, pre - 1)) : -1;
      erra = ($urandom_range(0, 4) == 0 && n > 0) ? int'($urandom_range(0, n - 1)) : -1;
      drib = mii && ($urandom_range(0, 3) == 0);
      gap  = int'($urandom_range(0, 3));
      fill_random(n);
      drive_frame(mii, pre, bad, erra, drib, gap);
    end

    repeat (8) tick();
    check_eq("beat_count", 64'(n_obs), 64'(n_exp));
    check_eq("unmatched_expected", 64'(exp_q.size()), 64'd0);
    check_eq("unmatched_observed", 64'(obs_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
